// File: rtl/cpu_pkg.sv
// Shared CPU types: word width, PC increment, NOP encoding,
// fetch FSM states and the {pc, insn} bundle carried by the fetch buffer.
package cpu_pkg;

    localparam int WORD     = 32;
    localparam int WORD_MSB = WORD - 1;

    localparam logic [WORD_MSB:0] PC_INC   = 32'd4;
    localparam logic [WORD_MSB:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT,
        HALT_ERR
    } ifu_state_t;

    typedef struct packed {
        logic [WORD_MSB:0] pc;
        logic [WORD_MSB:0] insn;
    } fetch_entry_t;

endpackage

// File: rtl/if_inst_fifo.sv
// Synchronous FIFO of {pc, insn} entries for the fetch stage.
// Ports: clk, rst, flush, push/push_entry, pop, head (entry at read pointer), count.
module if_inst_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_entry,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop  = pop && (count != '0);
        // A push into a full FIFO is only legal when a pop frees a slot.
        do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    end

    assign head = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, requests words from the ROM, buffers
// {pc, insn} and hands them to decode over valid/ready.
// Ports: clk, rst, redirect_valid/redirect_pc, halt, rom_cs/rom_as/rom_addr,
// rom_data/rom_rdy, inst_valid/inst_ready/inst_data/inst_pc,
// misalign_err (only when IFU_MISALIGN_CHECK_EN is defined).
module inst_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter int          ROM_ADDR_W = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [WORD_MSB:0]     redirect_pc,
    input  logic                  halt,
    output logic                  rom_cs,
    output logic                  rom_as,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [WORD_MSB:0]     rom_data,
    input  logic                  rom_rdy,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [WORD_MSB:0]     inst_data,
    output logic [WORD_MSB:0]     inst_pc
`ifdef IFU_MISALIGN_CHECK_EN
    ,
    output logic                  misalign_err
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    ifu_state_t        state;
    logic [WORD_MSB:0] pc;
    logic [WORD_MSB:0] req_pc;
    logic              inflight;
    logic              drop;
    logic [CNT_W-1:0]  fifo_count;
    fetch_entry_t      head;
    fetch_entry_t      push_entry;
    logic [WORD_MSB:0] target;
    logic              bad_target;
    logic [CNT_W:0]    occ;
    logic              pop;
    logic              push;
    logic              issue;
    logic              flush;

`ifdef IFU_MISALIGN_CHECK_EN
    assign target       = redirect_pc;
    assign bad_target   = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign misalign_err = (state == HALT_ERR);
`else
    logic unused_lsb;
    assign unused_lsb = ^redirect_pc[1:0];
    assign target     = {redirect_pc[WORD_MSB:2], 2'b00};
    assign bad_target = 1'b0;
`endif

    assign inst_valid = (fifo_count != '0);
    assign pop        = inst_valid && inst_ready;

    // Slots that will be taken once the pending response lands, net of
    // this cycle's pop; keeps 1/cycle issue with a 2-entry buffer.
    assign occ = {1'b0, fifo_count}
               + {{CNT_W{1'b0}}, inflight}
               - {{CNT_W{1'b0}}, pop};

    assign issue = (state == RUN) && !halt && !redirect_valid
                && (occ < (CNT_W+1)'(FIFO_DEPTH));

    assign push = inflight && rom_rdy && !drop && !redirect_valid
               && (state != HALT_ERR);

    assign flush = redirect_valid || (state == HALT_ERR);

    assign rom_cs   = issue;
    assign rom_as   = issue;
    assign rom_addr = issue ? pc[ROM_ADDR_W+1:2] : '0;

    assign push_entry.pc   = req_pc;
    assign push_entry.insn = rom_data;

    assign inst_data = inst_valid ? head.insn : '0;
    assign inst_pc   = inst_valid ? head.pc   : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (bad_target) begin
            state <= HALT_ERR;
        end else begin
            unique case (state)
                IDLE:     state <= RUN;
                RUN:      state <= halt ? HALT : RUN;
                HALT:     state <= halt ? HALT : RUN;
                HALT_ERR: state <= HALT_ERR;
                default:  state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            drop     <= 1'b0;
        end else begin
            // A response still owed after a redirect belongs to the old path.
            drop <= redirect_valid && inflight && !rom_rdy;
            if (issue) begin
                inflight <= 1'b1;
            end else if (rom_rdy) begin
                inflight <= 1'b0;
            end
            if (redirect_valid) begin
                pc <= target;
            end else if (issue) begin
                pc     <= pc + PC_INC;
                req_pc <= pc;
            end
        end
    end

    if_inst_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (fifo_count)
    );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit with a 1-cycle ROM model and a
// sequential-stream reference (next pc = previous + 4, or redirect target).
module tb_inst_fetch_unit;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        rom_cs;
    logic        rom_as;
    logic [11:0] rom_addr;
    logic [31:0] rom_data;
    logic        rom_rdy;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
`ifdef IFU_MISALIGN_CHECK_EN
    logic        misalign_err;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_pc;
    logic        s_cs, s_valid, s_pop;
    logic [11:0] s_addr;
    logic [31:0] s_pc, s_data;

    inst_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .rom_cs         (rom_cs),
        .rom_as         (rom_as),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .rom_rdy        (rom_rdy),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
`ifdef IFU_MISALIGN_CHECK_EN
        ,
        .misalign_err   (misalign_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM: word k holds A000_0000 + k, answered one cycle after cs&as.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_rdy  <= 1'b0;
            rom_data <= '0;
        end else begin
            rom_rdy  <= rom_cs && rom_as;
            rom_data <= 32'hA000_0000 + {20'h0, rom_addr};
        end
    end

    function automatic logic [31:0] rom_word(input logic [31:0] p);
        return 32'hA000_0000 + {20'h0, p[13:2]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        s_cs    = rom_cs && rom_as;
        s_addr  = rom_addr;
        s_valid = inst_valid;
        s_pc    = inst_pc;
        s_data  = inst_data;
        s_pop   = inst_valid && inst_ready && !redirect_valid && !rst;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt           = 1'b0;
        inst_ready     = 1'b0;
        tick();
        tick();
        rst    = 1'b0;
        exp_pc = 32'h0;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt           = 1'b0;
        inst_ready     = 1'b1;
        tick();
        sample();
        checks += 5;
        if (s_cs !== 1'b0) begin
            errors++; $display("FAIL reset_cs: got %b want 0", s_cs);
        end
        if (s_addr !== 12'h0) begin
            errors++; $display("FAIL reset_addr: got %h want 0", s_addr);
        end
        if (s_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", s_valid);
        end
        if (s_data !== 32'h0) begin
            errors++; $display("FAIL reset_data: got %h want 0", s_data);
        end
        if (s_pc !== 32'h0) begin
            errors++; $display("FAIL reset_pc: got %h want 0", s_pc);
        end
        tick();
    endtask

    task automatic test_sequential();
        int first_cs = -1;
        int first_v  = -1;
        int n_issue  = 0;
        do_reset();
        inst_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            sample();
            if (s_cs) begin
                checks++;
                if (s_addr !== 12'(n_issue)) begin
                    errors++;
                    $display("FAIL seq_addr: got %0d want %0d", s_addr, n_issue);
                end
                if (first_cs < 0) first_cs = c;
                n_issue++;
            end
            if (s_valid && first_v < 0) first_v = c;
            if (s_pop) begin
                checks++;
                if (s_pc !== exp_pc || s_data !== rom_word(exp_pc)) begin
                    errors++;
                    $display("FAIL seq_stream: pc=%h data=%h want pc=%h data=%h",
                             s_pc, s_data, exp_pc, rom_word(exp_pc));
                end
                exp_pc += 4;
            end
            tick();
        end
        checks += 2;
        if (first_cs < 0 || first_v != first_cs + 2) begin
            errors++;
            $display("FAIL seq_latency: first issue %0d first valid %0d want +2",
                     first_cs, first_v);
        end
        if (first_cs < 0 || n_issue != 16 - first_cs) begin
            errors++;
            $display("FAIL seq_throughput: issues %0d want %0d", n_issue, 16 - first_cs);
        end
    endtask

    task automatic test_backpressure();
        int n_issue = 0;
        int n_pop   = 0;
        do_reset();
        inst_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            sample();
            if (s_cs) n_issue++;
            tick();
        end
        checks += 2;
        if (n_issue != 2) begin
            errors++; $display("FAIL bp_issues: got %0d want 2", n_issue);
        end
        if (s_valid !== 1'b1 || s_cs !== 1'b0) begin
            errors++; $display("FAIL bp_hold: valid=%b cs=%b want 1 0", s_valid, s_cs);
        end
        inst_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            sample();
            if (s_pop) begin
                checks++;
                n_pop++;
                if (s_pc !== exp_pc || s_data !== rom_word(exp_pc)) begin
                    errors++;
                    $display("FAIL bp_stream: pc=%h data=%h want pc=%h data=%h",
                             s_pc, s_data, exp_pc, rom_word(exp_pc));
                end
                exp_pc += 4;
            end
            tick();
        end
        checks++;
        if (n_pop < 2) begin
            errors++; $display("FAIL bp_drain: popped %0d want >=2", n_pop);
        end
    endtask

    task automatic test_redirect();
        bit found = 0;
        bit got   = 0;
        do_reset();
        inst_ready = 1'b1;
        for (int c = 0; c < 20 && !found; c++) begin
            sample();
            if (s_pop) begin
                checks++;
                if (s_pc !== exp_pc || s_data !== rom_word(exp_pc)) begin
                    errors++;
                    $display("FAIL redir_pre: pc=%h data=%h want pc=%h", s_pc, s_data, exp_pc);
                end
                exp_pc += 4;
            end
            if (s_cs && s_addr == 12'd2) found = 1;
            tick();
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL redir_wait: no issue for pc 0x8 got 0 want 1");
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        sample();
        checks++;
        if (s_cs !== 1'b0) begin
            errors++; $display("FAIL redir_cs: got %b want 0", s_cs);
        end
        tick();
        redirect_valid = 1'b0;
        exp_pc = 32'h0000_0100;
        for (int c = 0; c < 8; c++) begin
            sample();
            if (s_pop) begin
                checks++;
                if (!got && s_data !== 32'hA000_0040) begin
                    errors++;
                    $display("FAIL redir_first: data=%h want a0000040", s_data);
                end
                if (s_pc !== exp_pc || s_data !== rom_word(exp_pc)) begin
                    errors++;
                    $display("FAIL redir_stream: pc=%h data=%h want pc=%h data=%h",
                             s_pc, s_data, exp_pc, rom_word(exp_pc));
                end
                got = 1;
                exp_pc += 4;
            end
            tick();
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL redir_timeout: pops 0 want >=1");
        end
    endtask

    task automatic test_halt();
        int n_after = 0;
        for (int c = 0; c < 18; c++) begin
            halt = (c >= 4 && c < 9);
            sample();
            if (halt) begin
                checks++;
                if (s_cs !== 1'b0) begin
                    errors++; $display("FAIL halt_cs: cycle %0d got %b want 0", c, s_cs);
                end
            end
            if (s_pop) begin
                checks++;
                if (c >= 9) n_after++;
                if (s_pc !== exp_pc || s_data !== rom_word(exp_pc)) begin
                    errors++;
                    $display("FAIL halt_stream: pc=%h data=%h want pc=%h data=%h",
                             s_pc, s_data, exp_pc, rom_word(exp_pc));
                end
                exp_pc += 4;
            end
            tick();
        end
        halt = 1'b0;
        checks++;
        if (n_after < 3) begin
            errors++; $display("FAIL halt_resume: pops %0d want >=3", n_after);
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        inst_ready = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        sample();
        checks++;
        if (s_valid !== 1'b1) begin
            errors++; $display("FAIL rstmid_full: valid=%b want 1", s_valid);
        end
        tick();
        rst = 1'b1;
        sample();
        checks += 2;
        if (s_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_valid: got %b want 0", s_valid);
        end
        if (s_cs !== 1'b0) begin
            errors++; $display("FAIL rstmid_cs: got %b want 0", s_cs);
        end
        tick();
        rst        = 1'b0;
        exp_pc     = 32'h0;
        inst_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            sample();
            if (s_cs && !seen) begin
                checks++;
                seen = 1;
                if (s_addr !== 12'h0) begin
                    errors++; $display("FAIL rstmid_addr: got %h want 0", s_addr);
                end
            end
            if (s_pop) begin
                checks++;
                if (s_pc !== exp_pc || s_data !== rom_word(exp_pc)) begin
                    errors++;
                    $display("FAIL rstmid_stream: pc=%h want pc=%h", s_pc, exp_pc);
                end
                exp_pc += 4;
            end
            tick();
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL rstmid_timeout: issue 0 want 1");
        end
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        do_reset();
        for (int c = 0; c < 500; c++) begin
            inst_ready     = ($urandom % 4) != 0;
            halt           = ($urandom % 12) == 0;
            redirect_valid = ($urandom % 15) == 0;
            tgt            = $urandom;
`ifdef IFU_MISALIGN_CHECK_EN
            tgt[1:0] = 2'b00;
`endif
            redirect_pc = tgt;
            sample();
            if (s_cs) begin
                checks++;
                if (halt || redirect_valid) begin
                    errors++;
                    $display("FAIL rnd_cs: cs=1 with halt=%b redirect=%b want cs=0",
                             halt, redirect_valid);
                end
            end
            if (s_pop) begin
                checks++;
                if (s_pc !== exp_pc || s_data !== rom_word(exp_pc)) begin
                    errors++;
                    $display("FAIL rnd_stream: cycle %0d pc=%h data=%h want pc=%h data=%h",
                             c, s_pc, s_data, exp_pc, rom_word(exp_pc));
                end
                exp_pc += 4;
            end
            tick();
            if (redirect_valid) exp_pc = {tgt[31:2], 2'b00};
        end
        redirect_valid = 1'b0;
        halt           = 1'b0;
    endtask

`ifdef IFU_MISALIGN_CHECK_EN
    task automatic test_misalign();
        do_reset();
        inst_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        tick();
        redirect_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            sample();
            checks += 3;
            if (misalign_err !== 1'b1) begin
                errors++; $display("FAIL mis_err: got %b want 1", misalign_err);
            end
            if (s_cs !== 1'b0) begin
                errors++; $display("FAIL mis_cs: got %b want 0", s_cs);
            end
            if (s_valid !== 1'b0) begin
                errors++; $display("FAIL mis_valid: got %b want 0", s_valid);
            end
            tick();
        end
        do_reset();
        sample();
        checks++;
        if (misalign_err !== 1'b0) begin
            errors++; $display("FAIL mis_clear: got %b want 0", misalign_err);
        end
    endtask
`else
    task automatic test_lsb_ignored();
        bit got = 0;
        do_reset();
        inst_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        tick();
        redirect_valid = 1'b0;
        exp_pc = 32'h0000_0100;
        for (int c = 0; c < 8; c++) begin
            sample();
            if (s_pop) begin
                checks++;
                got = 1;
                if (s_pc !== exp_pc || s_data !== rom_word(exp_pc)) begin
                    errors++;
                    $display("FAIL lsb_stream: pc=%h data=%h want pc=%h", s_pc, s_data, exp_pc);
                end
                exp_pc += 4;
            end
            tick();
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL lsb_timeout: pops 0 want >=1");
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_halt();
        test_reset_mid();
        test_random();
`ifdef IFU_MISALIGN_CHECK_EN
        test_misalign();
`else
        test_lsb_ignored();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
